// File: rtl/true_dual_port_bytewise_ram.sv
// True dual-port byte-write RAM on one clock with a configurable output
// pipeline, fixed same-address collision resolution and a post-reset clear sweep.
module true_dual_port_bytewise_ram #(
  parameter int               WIDTH          = 32,
  parameter int               DEPTH          = 1024,
  parameter int               BYTE_W         = 8,
  parameter string            MODE           = "READ_FIRST",
  parameter int               OUT_REGS       = 1,
  parameter int               CLEAR_ON_RESET = 1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0,
  localparam int              NB             = WIDTH / BYTE_W,
  localparam int              ADDR_W         = $clog2(DEPTH)
) (
  input  logic              clka,
  input  logic              rstb,
  output logic              ready,
  input  logic              a_en,
  input  logic [NB-1:0]     a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_din,
  output logic [WIDTH-1:0]  a_dout,
  output logic              a_valid,
  input  logic              b_en,
  input  logic [NB-1:0]     b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_din,
  output logic [WIDTH-1:0]  b_dout,
  output logic              b_valid,
  output logic              collision
);

  localparam int P = 2 + OUT_REGS;
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;
  localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
  localparam bit WF = (MODE == "WRITE_FIRST");
  localparam bit NC = (MODE == "NO_CHANGE");

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [0:0]       r_state;
  logic [ADDR_W:0]  r_cnt;
  logic [WIDTH-1:0] r_a_d [P];
  logic [WIDTH-1:0] r_b_d [P];
  logic [P-1:0]     r_a_v;
  logic [P-1:0]     r_b_v;
  logic             r_coll;

  logic             w_a_acc;
  logic             w_b_acc;
  logic             w_a_wr;
  logic             w_b_wr;
  logic             w_same;
  logic             w_sweep;
  logic             w_a_prod;
  logic             w_b_prod;
  logic [WIDTH-1:0] w_a_old;
  logic [WIDTH-1:0] w_b_old;
  logic [WIDTH-1:0] w_a_new;
  logic [WIDTH-1:0] w_b_new;
  logic [WIDTH-1:0] w_a_rd;
  logic [WIDTH-1:0] w_b_rd;

  assign ready   = (r_state == S_RUN);
  assign w_sweep = (r_state == S_CLEAR) && !rstb && (CLEAR_ON_RESET != 0);

  assign w_a_acc = a_en && ready && !rstb && ({1'b0, a_addr} < LIMIT);
  assign w_b_acc = b_en && ready && !rstb && ({1'b0, b_addr} < LIMIT);
  assign w_a_wr  = w_a_acc && (a_we != '0);
  assign w_b_wr  = w_b_acc && (b_we != '0);
  assign w_same  = w_a_acc && w_b_acc && (a_addr == b_addr);

  assign w_a_old = r_mem[a_addr];
  assign w_b_old = r_mem[b_addr];

  // On a shared address both ports see the same resolved word; A wins shared lanes
  always_comb begin
    w_a_new = w_a_old;
    w_b_new = w_b_old;
    for (int i = 0; i < NB; i++) begin
      if (w_same && b_we[i])
        w_a_new[i*BYTE_W +: BYTE_W] = b_din[i*BYTE_W +: BYTE_W];
      if (a_we[i])
        w_a_new[i*BYTE_W +: BYTE_W] = a_din[i*BYTE_W +: BYTE_W];
      if (b_we[i])
        w_b_new[i*BYTE_W +: BYTE_W] = b_din[i*BYTE_W +: BYTE_W];
      if (w_same && a_we[i])
        w_b_new[i*BYTE_W +: BYTE_W] = a_din[i*BYTE_W +: BYTE_W];
    end
  end

  assign w_a_prod = w_a_acc && !(NC && w_a_wr);
  assign w_b_prod = w_b_acc && !(NC && w_b_wr);
  assign w_a_rd   = (WF && w_a_wr) ? w_a_new : w_a_old;
  assign w_b_rd   = (WF && w_b_wr) ? w_b_new : w_b_old;

  always_ff @(posedge clka) begin
    if (rstb) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else if (r_state == S_CLEAR) begin
      if (CLEAR_ON_RESET == 0 || r_cnt == LAST)
        r_state <= S_RUN;
      if (CLEAR_ON_RESET != 0)
        r_cnt <= r_cnt + ONE;
    end
  end

  always_ff @(posedge clka) begin
    if (w_sweep) begin
      r_mem[r_cnt[ADDR_W-1:0]] <= CLEAR_VALUE;
    end else begin
      if (w_b_wr)
        r_mem[b_addr] <= w_b_new;
      if (w_a_wr)
        r_mem[a_addr] <= w_a_new;
    end
  end

  // Data stages only load behind a valid, so the last stage holds between results
  always_ff @(posedge clka) begin
    if (rstb) begin
      r_a_v  <= '0;
      r_b_v  <= '0;
      r_coll <= 1'b0;
      for (int i = 0; i < P; i++) begin
        r_a_d[i] <= '0;
        r_b_d[i] <= '0;
      end
    end else begin
      r_a_v[0] <= w_a_prod;
      r_b_v[0] <= w_b_prod;
      if (w_a_prod)
        r_a_d[0] <= w_a_rd;
      if (w_b_prod)
        r_b_d[0] <= w_b_rd;
      for (int i = 1; i < P; i++) begin
        r_a_v[i] <= r_a_v[i-1];
        r_b_v[i] <= r_b_v[i-1];
        if (r_a_v[i-1])
          r_a_d[i] <= r_a_d[i-1];
        if (r_b_v[i-1])
          r_b_d[i] <= r_b_d[i-1];
      end
      r_coll <= w_same && (w_a_wr || w_b_wr);
    end
  end

  assign a_dout    = r_a_d[P-1];
  assign a_valid   = r_a_v[P-1];
  assign b_dout    = r_b_d[P-1];
  assign b_valid   = r_b_v[P-1];
  assign collision = r_coll;

endmodule
